rob_commit: RTL
===============

ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 Parameter ROB_SIZE, default 4, number of entries; power of two, at least 2.
REQ-002 Parameter REG_LEN, default 8, data width; matches the register-file data width.
REQ-003 Parameter RF_SIZE_LOG, default 2, destination-register index width.
REQ-004 Derived width RSL = log2(ROB_SIZE).
REQ-005 Ports:
- clk  input  1  single clock; all state changes on posedge.
- rst  input  1  reset; synchronous, active-high.
- alloc_valid  input  1  request a new entry in program order.
- alloc_rd  input  RF_SIZE_LOG  destination register of the new entry.
- alloc_ready  output  1  entry available.
- alloc_tag  output  RSL  index the new entry will receive (equals tail).
- wb_valid  input  1  result arriving, any order.
- wb_tag  input  RSL  entry the result belongs to.
- wb_data  input  REG_LEN  result value.
- commit_wen  output  1  drives the register-file write enable.
- commit_rd  output  RF_SIZE_LOG  drives the register-file write index.
- commit_rd_data  output  REG_LEN  drives the register-file write data.
- count  output  RSL+1  number of occupied entries.
- empty  output  1  count == 0.

Function
REQ-006 Each entry SHALL hold busy, done, rd and data; head and tail pointers SHALL be RSL bits and wrap modulo ROB_SIZE.
REQ-007 Allocation: alloc_ready = (count < ROB_SIZE), independent of a same-cycle commit.
- On posedge with alloc_valid && alloc_ready: entry[tail] gets busy=1, done=0, rd=alloc_rd; tail advances by 1.
REQ-008 alloc_valid while alloc_ready=0 SHALL be ignored with no state change.
REQ-009 Writeback: on posedge with wb_valid, if entry[wb_tag] has busy=1 and done=0, set done=1 and data=wb_data.
- Writeback to a non-busy or already-done entry SHALL be ignored.
REQ-010 Commit outputs SHALL be combinational from head:
- commit_wen = busy[head] && done[head].
- commit_rd = rd[head]; commit_rd_data = data[head].
REQ-011 On posedge with commit_wen=1: entry[head] gets busy=0, done=0; head advances by 1. At most one commit per cycle.
REQ-012 Latency: writeback sampled at edge N to the head entry SHALL give commit_wen=1 in the cycle after edge N, so the register file is written at edge N+1.
REQ-013 Simultaneous alloc and commit: count unchanged, both pointers advance.
- With ROB_SIZE entries full, the freed slot becomes allocatable only in the next cycle.
REQ-014 Simultaneous writeback and commit on different entries: both take effect.
REQ-015 Writeback to the head entry in the cycle it commits cannot occur, because done=1 already blocks it.
REQ-016 Out-of-order completion: younger done entries SHALL wait until all older entries commit; commit order equals allocation order.
REQ-017 count SHALL be a register updated as +1 on alloc, -1 on commit, unchanged on both or neither; it never exceeds ROB_SIZE.

Reset
REQ-018 With rst high at posedge:
- every entry gets busy=0, done=0; head=0, tail=0, count=0.
- data and rd contents need not be cleared.
REQ-019 Reset outputs:
- commit_wen=0, empty=1, alloc_ready=1, alloc_tag=0, count=0.
- commit_rd and commit_rd_data are don't-care while commit_wen=0.
REQ-020 rst SHALL override alloc, writeback and commit in the same cycle, including mid-operation with entries in flight.

Configuration
REQ-021 Macro ROB_COMMIT_FLUSH_EN.
- Defined: adds port flush, input, 1 bit.
- On posedge with flush=1: same effect as reset on entries, pointers and count.
- While flush=1: commit_wen is forced 0, and alloc and writeback are ignored.
- Undefined: no flush port; behaviour as REQ-006 to REQ-020 only.

Verification
REQ-022 Reset, then alloc rd=1,2,3 (tags 0,1,2), then wb tag0=0x11, tag1=0x22, tag2=0x33 in order -> commit_wen pulses three consecutive cycles with (1,0x11),(2,0x22),(3,0x33); then empty=1.
REQ-023 Alloc rd=1,2; wb tag1=0xBB, then two cycles later tag0=0xAA -> no commit before the tag0 writeback; then (1,0xAA) then (2,0xBB) on consecutive cycles.
REQ-024 Alloc 4 entries -> alloc_ready=0, count=4.
- A 5th alloc is ignored.
- wb tag0, then alloc in the commit cycle -> alloc refused; accepted next cycle with alloc_tag=0 (wrap).
REQ-025 Run 10 alloc/wb/commit triples through ROB_SIZE=4 -> tags wrap 0..3,0..3,0,1; commit order matches allocation order; count never exceeds 4.
REQ-026 Duplicate wb to tag0 (0x55 then 0x66) before commit, plus wb to an unallocated tag -> commits 0x55; no spurious commit_wen.
REQ-027 With 3 entries busy, assert rst (or flush with ROB_COMMIT_FLUSH_EN) alongside wb_valid -> next cycle count=0, empty=1, commit_wen=0, alloc_tag=0.

Source files
------------

// File: rtl/rob_commit_if.sv
// ============================================================================
// Module      : rob_commit_if
// Description : Allocation, writeback and commit bundle for rob_commit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rob_commit_if #(
   parameter int ROB_SIZE    = 4,
   parameter int REG_LEN     = 8,
   parameter int RF_SIZE_LOG = 2
);
   localparam int RSL = $clog2(ROB_SIZE);

   logic                   alloc_valid;
   logic [RF_SIZE_LOG-1:0] alloc_rd;
   logic                   alloc_ready;
   logic [RSL-1:0]         alloc_tag;
   logic                   wb_valid;
   logic [RSL-1:0]         wb_tag;
   logic [REG_LEN-1:0]     wb_data;
   logic                   commit_wen;
   logic [RF_SIZE_LOG-1:0] commit_rd;
   logic [REG_LEN-1:0]     commit_rd_data;
   logic [RSL:0]           count;
   logic                   empty;

   modport master (
      output alloc_valid, alloc_rd, wb_valid, wb_tag, wb_data,
      input  alloc_ready, alloc_tag, commit_wen, commit_rd, commit_rd_data,
             count, empty
   );

   modport slave (
      input  alloc_valid, alloc_rd, wb_valid, wb_tag, wb_data,
      output alloc_ready, alloc_tag, commit_wen, commit_rd, commit_rd_data,
             count, empty
   );
endinterface

`default_nettype wire

// File: rtl/rob_commit.sv
// ============================================================================
// Module      : rob_commit
// Description : In-order commit reorder buffer; out-of-order writeback.
//               Optional synchronous flush port under ROB_COMMIT_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_commit #(
   parameter int ROB_SIZE    = 4,
   parameter int REG_LEN     = 8,
   parameter int RF_SIZE_LOG = 2
) (
   input  wire logic clk,
   input  wire logic rst,
`ifdef ROB_COMMIT_FLUSH_EN
   input  wire logic flush,
`endif
   rob_commit_if.slave bus
);
   localparam int RSL = $clog2(ROB_SIZE);
   localparam logic [RSL:0]   c_full_count = (RSL+1)'(ROB_SIZE);
   localparam logic [RSL-1:0] c_ptr_one    = RSL'(1);

   logic [ROB_SIZE-1:0]    r_busy;
   logic [ROB_SIZE-1:0]    r_done;
   logic [RF_SIZE_LOG-1:0] r_rd   [ROB_SIZE];
   logic [REG_LEN-1:0]     r_data [ROB_SIZE];
   logic [RSL-1:0]         r_head;
   logic [RSL-1:0]         r_tail;
   logic [RSL:0]           r_count;

   logic w_flush;
   logic w_alloc_ready;
   logic w_alloc_fire;
   logic w_wb_fire;
   logic w_commit;

`ifdef ROB_COMMIT_FLUSH_EN
   assign w_flush = flush;
`else
   assign w_flush = 1'b0;
`endif

   // Full-ness is judged on the registered count only, so a slot freed by a
   // commit this cycle cannot be reused until the next one.
   assign w_alloc_ready = (r_count < c_full_count);
   assign w_alloc_fire  = bus.alloc_valid && w_alloc_ready && !w_flush;
   assign w_wb_fire     = bus.wb_valid && r_busy[bus.wb_tag] &&
                          !r_done[bus.wb_tag] && !w_flush;
   assign w_commit      = r_busy[r_head] && r_done[r_head] && !w_flush;

   assign bus.alloc_ready    = w_alloc_ready;
   assign bus.alloc_tag      = r_tail;
   assign bus.commit_wen     = w_commit;
   assign bus.commit_rd      = r_rd[r_head];
   assign bus.commit_rd_data = r_data[r_head];
   assign bus.count          = r_count;
   assign bus.empty          = (r_count == '0);

   // Commit, writeback and allocation never touch the same entry in one
   // cycle: the head is done, and the tail is free unless the buffer is full.
   always_ff @(posedge clk) begin
      if (rst || w_flush) begin
         r_busy  <= '0;
         r_done  <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_commit) begin
            r_busy[r_head] <= 1'b0;
            r_done[r_head] <= 1'b0;
            r_head         <= r_head + c_ptr_one;
         end
         if (w_wb_fire) begin
            r_done[bus.wb_tag] <= 1'b1;
         end
         if (w_alloc_fire) begin
            r_busy[r_tail] <= 1'b1;
            r_done[r_tail] <= 1'b0;
            r_tail         <= r_tail + c_ptr_one;
         end
         case ({w_alloc_fire, w_commit})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_wb_fire) begin
         r_data[bus.wb_tag] <= bus.wb_data;
      end
      if (!rst && w_alloc_fire) begin
         r_rd[r_tail] <= bus.alloc_rd;
      end
   end

endmodule

`default_nettype wire
